reg_access_arbiter: RTL and testbench



---
 rtl/reg_access_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_access_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register among N_REQ requesters (IDLE/XFER/ACK).
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module reg_access_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    wr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  output logic [DW-1:0]       reg_din,
  output logic                reg_we,
  input  logic [DW-1:0]       reg_dout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [IW-1:0]    win_q,     win_d;
  logic             wr_q,      wr_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic [DW-1:0]    rdata_q,   rdata_d;
  logic             busy_q,    busy_d;
  logic [DW-1:0]    reg_din_q, reg_din_d;
  logic             reg_we_q,  reg_we_d;

  logic [IW-1:0]    ptr_s;
  logic [IW-1:0]    win_s;
  logic [IW-1:0]    idx_s;
  logic             found_s;

`ifdef REG_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_ACK) begin
      ptr_d = (int'(win_q) == N_REQ - 1) ? '0 : win_q + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`endif

  // First set request scanning upward from the pointer, wrapping around.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = IW'((int'(ptr_s) + k) % N_REQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    wr_d      = wr_q;
    gnt_d     = '0;
    rdata_d   = rdata_q;
    reg_din_d = reg_din_q;
    reg_we_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d  = S_XFER;
          win_d    = win_s;
          wr_d     = wr[win_s];
          reg_we_d = wr[win_s];
          if (wr[win_s]) begin
            reg_din_d = wdata[DW*int'(win_s) +: DW];
          end else begin
            reg_din_d = reg_din_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        state_d        = S_ACK;
        gnt_d[win_q]   = 1'b1;
        // The register only updates at this edge, so a write reports its own data.
        rdata_d        = wr_q ? reg_din_q : reg_dout;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      wr_q      <= 1'b0;
      gnt_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      reg_din_q <= '0;
      reg_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      wr_q      <= wr_d;
      gnt_q     <= gnt_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      reg_din_q <= reg_din_d;
      reg_we_q  <= reg_we_d;
    end
  end

  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign reg_din = reg_din_q;
  assign reg_we  = reg_we_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural 16-bit register model.
module tb_reg_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  wr  = 4'b0000;
  logic [63:0] wdata = 64'h0;
  logic [3:0]  gnt;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] reg_din;
  logic        reg_we;
  logic [15:0] reg_dout;
  logic [15:0] reg_mem = 16'h0000;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  reg_access_arbiter #(.N_REQ(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .busy(busy),
    .reg_din(reg_din), .reg_we(reg_we), .reg_dout(reg_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_we) reg_mem <= reg_din;
  end

  assign reg_dout = reg_mem;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({gnt, rdata, busy, reg_din, reg_we} !== {4'b0, 16'h0, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got gnt=%b rdata=%h busy=%b reg_din=%h reg_we=%b, want all zero",
               gnt, rdata, busy, reg_din, reg_we);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_write;
    req = 4'b0010; wr = 4'b0010; wdata[31:16] = 16'hA5A5;
    step();
    checks++;
    if ({reg_we, reg_din, busy, gnt} !== {1'b1, 16'hA5A5, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL write_xfer: got we=%b din=%h busy=%b gnt=%b, want we=1 din=a5a5 busy=1 gnt=0000",
               reg_we, reg_din, busy, gnt);
    end
    step();
    checks++;
    if ({gnt, rdata, reg_we, busy} !== {4'b0010, 16'hA5A5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL write_ack: got gnt=%b rdata=%h we=%b busy=%b, want gnt=0010 rdata=a5a5 we=0 busy=1",
               gnt, rdata, reg_we, busy);
    end
    req = 4'b0000; wr = 4'b0000;
    step();
    checks++;
    if ({gnt, busy, reg_we, reg_din, reg_mem} !== {4'b0, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5}) begin
      errors++;
      $display("FAIL write_idle: got gnt=%b busy=%b we=%b din=%h mem=%h, want 0 0 0 a5a5 a5a5",
               gnt, busy, reg_we, reg_din, reg_mem);
    end
  endtask

  task automatic test_read_after_write;
    int we_seen;
    we_seen = 0;
    req = 4'b1000; wr = 4'b0000;
    step();
    if (reg_we) we_seen++;
    step();
    if (reg_we) we_seen++;
    checks++;
    if ({gnt, rdata} !== {4'b1000, 16'hA5A5}) begin
      errors++;
      $display("FAIL read_ack: got gnt=%b rdata=%h, want gnt=1000 rdata=a5a5", gnt, rdata);
    end
    req = 4'b0000;
    step();
    if (reg_we) we_seen++;
    checks++;
    if (we_seen !== 0) begin
      errors++;
      $display("FAIL read_no_we: got %0d cycles with reg_we, want 0", we_seen);
    end
  endtask

  task automatic test_round_robin;
    int last_cyc;
    int n;
    logic [3:0] exp_gnt;
    last_cyc = 0;
    req = 4'b1111; wr = 4'b0000;
    for (int t = 0; t < 12; t++) begin
      n = 0;
      while (gnt === 4'b0000 && n < 10) begin
        step();
        n++;
      end
`ifdef REG_ARB_FIXED_PRIO_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = 4'b0001 << (t % 4);
`endif
      checks++;
      if (gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_order[%0d]: got gnt=%b, want %b", t, gnt, exp_gnt);
      end
      if (t > 0) begin
        checks++;
        if (cyc - last_cyc !== 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles, want 3", t, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      if (t == 11) req = 4'b0000;
      step();
    end
    step();
  endtask

  task automatic test_withdraw;
    req = 4'b1100; wr = 4'b0000;
    step();
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL withdraw_gnt: got gnt=%b, want 0100", gnt);
    end
    step();
    step();
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL withdraw_next: got gnt=%b, want 1000", gnt);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid;
    req = 4'b0010; wr = 4'b0010; wdata[31:16] = 16'h1234;
    step();
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_ack: got gnt=%b, want 0010", gnt);
    end
    rst = 1'b0; req = 4'b0000; wr = 4'b0000;
    step();
    checks++;
    if ({gnt, busy, rdata, reg_we, reg_mem} !== {4'b0, 1'b0, 16'h0, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL rstmid_state: got gnt=%b busy=%b rdata=%h we=%b mem=%h, want 0 0 0000 0 1234",
               gnt, busy, rdata, reg_we, reg_mem);
    end
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_ptr: got gnt=%b, want 0001", gnt);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_wrap_idle;
    req = 4'b0100;
    step();
    step();
    checks++;
    if ({gnt, rdata} !== {4'b0100, 16'h1234}) begin
      errors++;
      $display("FAIL wrap_setup: got gnt=%b rdata=%h, want 0100 1234", gnt, rdata);
    end
    req = 4'b0000;
    step();
    req = 4'b0001;
    step();
    step();
    checks++;
    if ({gnt, rdata} !== {4'b0001, 16'h1234}) begin
      errors++;
      $display("FAIL wrap_gnt: got gnt=%b rdata=%h, want 0001 1234", gnt, rdata);
    end
    req = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({busy, gnt, reg_we, rdata, reg_din} !== {1'b0, 4'b0, 1'b0, 16'h1234, 16'h0000}) begin
        errors++;
        $display("FAIL idle_stable[%0d]: got busy=%b gnt=%b we=%b rdata=%h din=%h, want 0 0000 0 1234 0000",
                 i, busy, gnt, reg_we, rdata, reg_din);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_after_write();
    test_round_robin();
    test_withdraw();
    test_reset_mid();
    test_wrap_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
